// File: rtl/tile_grid_compositor_if.sv
// Scrambler write port of the tile grid compositor.
// The master drives the strobe, address and data; the slave reports acceptance.
interface tile_grid_compositor_if #(
  parameter int IDX_BITS = 5,
  parameter int VAL_BITS = 5
);
  logic                wr_en;
  logic [IDX_BITS-1:0] wr_addr;
  logic [VAL_BITS-1:0] wr_data;
  logic                wr_ready;

  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/tile_grid_compositor.sv
// COLS x ROWS tile-sort grid with cursor/hold/swap FSM and a 2-stage VGA renderer.
// Tiles hold values; the puzzle is solved when every tile[i] == i.
module tile_grid_compositor #(
  parameter int COLS       = 5,
  parameter int ROWS       = 5,
  parameter int TILE_SHIFT = 6,
  parameter int ORIGIN_X   = 160,
  parameter int ORIGIN_Y   = 80,
  parameter int BORDER     = 2,
  parameter int VAL_BITS   = 5,
  parameter int IDX_BITS   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         counter_x,
  input  logic [8:0]          counter_y,
  input  logic                in_display_area,
  input  logic                h_sync_in,
  input  logic                v_sync_in,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_center,
  tile_grid_compositor_if.slave wrBus,
  output logic [IDX_BITS-1:0] cursor_idx,
  output logic                held,
  output logic [15:0]         swap_count,
  output logic                solved,
  output logic                vga_h_sync,
  output logic                vga_v_sync,
  output logic                vga_r,
  output logic                vga_g,
  output logic                vga_b
);

  localparam int NTILES = COLS * ROWS;
  localparam int TILE   = 1 << TILE_SHIFT;
  localparam int GRID_W = COLS << TILE_SHIFT;
  localparam int GRID_H = ROWS << TILE_SHIFT;
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, HELD, SWAP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          col_q, col_d, row_q, row_d;
  logic [3:0]          dstCol_q, dstCol_d, dstRow_q, dstRow_d;
  logic [15:0]         swapCount_q, swapCount_d;
  logic [VAL_BITS-1:0] tile_q [NTILES];
  logic                solved_q;

  logic [3:0]          nextCol, nextRow;
  logic                hMove, vMove;
  logic [IDX_BITS-1:0] curIdx, dstIdx;
  logic                wrAccept, allMatch;

  function automatic logic [IDX_BITS-1:0] idxOf(input logic [3:0] c, input logic [3:0] r);
    return IDX_BITS'(int'(r) * COLS + int'(c));
  endfunction

  // Opposing pulses on one axis cancel; the two axes are independent so diagonals apply both.
  always_comb begin
    nextCol = col_q;
    nextRow = row_q;
    hMove   = 1'b0;
    vMove   = 1'b0;
    if (btn_left && !btn_right) begin
      hMove   = 1'b1;
      nextCol = (col_q == 4'd0) ? COL_MAX : col_q - 4'd1;
    end else if (btn_right && !btn_left) begin
      hMove   = 1'b1;
      nextCol = (col_q == COL_MAX) ? 4'd0 : col_q + 4'd1;
    end
    if (btn_up && !btn_down) begin
      vMove   = 1'b1;
      nextRow = (row_q == 4'd0) ? ROW_MAX : row_q - 4'd1;
    end else if (btn_down && !btn_up) begin
      vMove   = 1'b1;
      nextRow = (row_q == ROW_MAX) ? 4'd0 : row_q + 4'd1;
    end
  end

  assign curIdx   = idxOf(col_q, row_q);
  assign dstIdx   = idxOf(dstCol_q, dstRow_q);
  assign wrAccept = wrBus.wr_en && (state_q == IDLE) && (int'(wrBus.wr_addr) < NTILES);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    dstCol_d    = dstCol_q;
    dstRow_d    = dstRow_q;
    swapCount_d = swapCount_q;
    case (state_q)
      IDLE: begin
        if (btn_center) begin
          state_d = HELD;
        end else begin
          col_d = nextCol;
          row_d = nextRow;
        end
      end
      HELD: begin
        if (btn_center) begin
          state_d = IDLE;
        end else if (hMove || vMove) begin
          state_d  = SWAP;
          dstCol_d = nextCol;
          dstRow_d = nextRow;
        end
      end
      SWAP: begin
        col_d   = dstCol_q;
        row_d   = dstRow_q;
        state_d = HELD;
        if (swapCount_q != 16'hFFFF) swapCount_d = swapCount_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 4'd0;
      row_q       <= 4'd0;
      dstCol_q    <= 4'd0;
      dstRow_q    <= 4'd0;
      swapCount_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      dstCol_q    <= dstCol_d;
      dstRow_q    <= dstRow_d;
      swapCount_q <= swapCount_d;
    end
  end

  // The exchange happens on a single edge, so a reset can never leave a half-swapped pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NTILES; i++) tile_q[i] <= VAL_BITS'(i);
    end else if (state_q == SWAP) begin
      tile_q[curIdx] <= tile_q[dstIdx];
      tile_q[dstIdx] <= tile_q[curIdx];
    end else if (wrAccept) begin
      tile_q[wrBus.wr_addr] <= wrBus.wr_data;
    end
  end

  always_comb begin
    allMatch = 1'b1;
    for (int i = 0; i < NTILES; i++) begin
      if (tile_q[i] != VAL_BITS'(i)) allMatch = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) solved_q <= 1'b1;
    else     solved_q <= allMatch;
  end

  assign cursor_idx     = curIdx;
  assign held           = (state_q != IDLE);
  assign swap_count     = swapCount_q;
  assign solved         = solved_q;
  assign wrBus.wr_ready = (state_q == IDLE);

  logic [10:0]           dx;
  logic [8:0]            dy;
  logic                  inGrid;
  logic                  s1InGrid_q, s1De_q, s1Hs_q, s1Vs_q;
  logic [3:0]            s1Col_q, s1Row_q;
  logic [TILE_SHIFT-1:0] s1OffX_q, s1OffY_q;

  // Negative offsets wrap to large unsigned values and therefore land outside the grid.
  assign dx     = counter_x - 11'(ORIGIN_X);
  assign dy     = counter_y - 9'(ORIGIN_Y);
  assign inGrid = (int'(dx) < GRID_W) && (int'(dy) < GRID_H);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1InGrid_q <= 1'b0;
      s1De_q     <= 1'b0;
      s1Hs_q     <= 1'b0;
      s1Vs_q     <= 1'b0;
      s1Col_q    <= 4'd0;
      s1Row_q    <= 4'd0;
      s1OffX_q   <= '0;
      s1OffY_q   <= '0;
    end else begin
      s1InGrid_q <= inGrid;
      s1De_q     <= in_display_area;
      s1Hs_q     <= h_sync_in;
      s1Vs_q     <= v_sync_in;
      s1Col_q    <= 4'(dx >> TILE_SHIFT);
      s1Row_q    <= 4'(dy >> TILE_SHIFT);
      s1OffX_q   <= dx[TILE_SHIFT-1:0];
      s1OffY_q   <= dy[TILE_SHIFT-1:0];
    end
  end

  logic [IDX_BITS-1:0] pixIdx;
  logic [VAL_BITS-1:0] pixVal;
  logic                onBorder, isCursor;
  logic [2:0]          rgb_d, rgb_q;
  logic                s2Hs_q, s2Vs_q;

  assign pixIdx   = idxOf(s1Col_q, s1Row_q);
  assign pixVal   = (s1InGrid_q && (int'(pixIdx) < NTILES)) ? tile_q[pixIdx] : '0;
  assign isCursor = (s1Col_q == col_q) && (s1Row_q == row_q);
  assign onBorder = (int'(s1OffX_q) < BORDER) || (int'(s1OffX_q) >= TILE - BORDER) ||
                    (int'(s1OffY_q) < BORDER) || (int'(s1OffY_q) >= TILE - BORDER);

  always_comb begin
    rgb_d = 3'b000;
    if (s1De_q && s1InGrid_q) begin
      if (isCursor && onBorder) begin
        rgb_d = held ? 3'b110 : 3'b111;
      end else if (pixVal != '0) begin
        rgb_d = (pixVal[2:0] == 3'b000) ? 3'b001 : pixVal[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q  <= 3'b000;
      s2Hs_q <= 1'b0;
      s2Vs_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      s2Hs_q <= s1Hs_q;
      s2Vs_q <= s1Vs_q;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_h_sync = s2Hs_q;
  assign vga_v_sync = s2Vs_q;

endmodule

// File: tb/tb_tile_grid_compositor.sv
// Directed self-checking bench for tile_grid_compositor: cursor, swap, writes, render and reset.
module tb_tile_grid_compositor;

  localparam logic [4:0] BL = 5'b10000;
  localparam logic [4:0] BR = 5'b01000;
  localparam logic [4:0] BU = 5'b00100;
  localparam logic [4:0] BD = 5'b00010;
  localparam logic [4:0] BC = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] counterX;
  logic [8:0]  counterY;
  logic        de, hsIn, vsIn;
  logic        btnLeft, btnRight, btnUp, btnDown, btnCenter;
  logic [4:0]  cursorIdx;
  logic        held, solved, vgaHs, vgaVs, vgaR, vgaG, vgaB;
  logic [15:0] swapCount;
  logic [2:0]  rgb;

  int checks = 0;
  int errors = 0;

  tile_grid_compositor_if #(.IDX_BITS(5), .VAL_BITS(5)) wrBus ();

  tile_grid_compositor dut (
    .clk(clk), .rst(rst),
    .counter_x(counterX), .counter_y(counterY), .in_display_area(de),
    .h_sync_in(hsIn), .v_sync_in(vsIn),
    .btn_left(btnLeft), .btn_right(btnRight), .btn_up(btnUp), .btn_down(btnDown),
    .btn_center(btnCenter),
    .wrBus(wrBus),
    .cursor_idx(cursorIdx), .held(held), .swap_count(swapCount), .solved(solved),
    .vga_h_sync(vgaHs), .vga_v_sync(vgaVs), .vga_r(vgaR), .vga_g(vgaG), .vga_b(vgaB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [2:0] tileColour(input int v);
    logic [4:0] val;
    val = 5'(v);
    if (val == 5'd0) return 3'b000;
    if (val[2:0] == 3'b000) return 3'b001;
    return val[2:0];
  endfunction

  // Called at a falling edge; pulses for one rising edge, then idles for idle cycles.
  task automatic applyStimulus(input logic [4:0] btn, input logic we, input logic [4:0] addr,
                               input logic [4:0] data, input int idle);
    {btnLeft, btnRight, btnUp, btnDown, btnCenter} = btn;
    wrBus.wr_en   = we;
    wrBus.wr_addr = addr;
    wrBus.wr_data = data;
    @(negedge clk);
    {btnLeft, btnRight, btnUp, btnDown, btnCenter} = 5'b0;
    wrBus.wr_en = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic pixelAt(input int x, input int y, input logic en, output logic [2:0] c);
    counterX = 11'(x);
    counterY = 9'(y);
    de       = en;
    @(posedge clk);
    @(posedge clk);
    #1 c = {vgaR, vgaG, vgaB};
    @(negedge clk);
  endtask

  task automatic readTile(input int idx, output logic [2:0] c);
    pixelAt(160 + (idx % 5) * 64 + 32, 80 + (idx / 5) * 64 + 32, 1'b1, c);
  endtask

  initial begin
    rst = 1'b1;
    counterX = '0; counterY = '0; de = 1'b0; hsIn = 1'b0; vsIn = 1'b0;
    {btnLeft, btnRight, btnUp, btnDown, btnCenter} = 5'b0;
    wrBus.wr_en = 1'b0; wrBus.wr_addr = '0; wrBus.wr_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cursor", 32'(cursorIdx), 32'd0);
    checkOutput("rst_held", 32'(held), 32'd0);
    checkOutput("rst_swaps", 32'(swapCount), 32'd0);
    checkOutput("rst_solved", 32'(solved), 32'd1);
    checkOutput("rst_wr_ready", 32'(wrBus.wr_ready), 32'd1);
    checkOutput("rst_rgb", 32'({vgaR, vgaG, vgaB}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Render: latency and sync alignment at the grid origin.
    pixelAt(100, 50, 1'b1, rgb);
    checkOutput("outside_tl", 32'(rgb), 32'd0);
    counterX = 11'd160; counterY = 9'd80; de = 1'b1; hsIn = 1'b1; vsIn = 1'b1;
    @(posedge clk);
    #1 checkOutput("lat1_rgb", 32'({vgaR, vgaG, vgaB}), 32'd0);
    checkOutput("lat1_hs", 32'(vgaHs), 32'd0);
    @(posedge clk);
    #1 checkOutput("lat2_rgb", 32'({vgaR, vgaG, vgaB}), 32'd7);
    checkOutput("lat2_hs", 32'(vgaHs), 32'd1);
    checkOutput("lat2_vs", 32'(vgaVs), 32'd1);
    @(negedge clk);
    hsIn = 1'b0; vsIn = 1'b0;

    readTile(0, rgb);  checkOutput("tile0", 32'(rgb), 32'(tileColour(0)));
    readTile(1, rgb);  checkOutput("tile1", 32'(rgb), 32'(tileColour(1)));
    readTile(3, rgb);  checkOutput("tile3", 32'(rgb), 32'(tileColour(3)));
    readTile(5, rgb);  checkOutput("tile5", 32'(rgb), 32'(tileColour(5)));
    readTile(7, rgb);  checkOutput("tile7", 32'(rgb), 32'(tileColour(7)));
    readTile(24, rgb); checkOutput("tile24", 32'(rgb), 32'd1);
    pixelAt(161, 112, 1'b1, rgb); checkOutput("border_in", 32'(rgb), 32'd7);
    pixelAt(162, 112, 1'b1, rgb); checkOutput("border_out", 32'(rgb), 32'd0);
    pixelAt(223, 112, 1'b1, rgb); checkOutput("border_right", 32'(rgb), 32'd7);
    pixelAt(224, 80, 1'b1, rgb);  checkOutput("tile1_corner", 32'(rgb), 32'd1);
    pixelAt(256, 112, 1'b0, rgb); checkOutput("blanked", 32'(rgb), 32'd0);
    pixelAt(159, 100, 1'b1, rgb); checkOutput("left_of_grid", 32'(rgb), 32'd0);
    pixelAt(479, 100, 1'b1, rgb); checkOutput("last_col", 32'(rgb), 32'd4);
    pixelAt(480, 100, 1'b1, rgb); checkOutput("right_of_grid", 32'(rgb), 32'd0);
    pixelAt(192, 400, 1'b1, rgb); checkOutput("below_grid", 32'(rgb), 32'd0);

    // Cursor movement with wrap, cancellation and diagonals.
    applyStimulus(BL, 1'b0, 5'd0, 5'd0, 0);      checkOutput("wrap_left", 32'(cursorIdx), 32'd4);
    applyStimulus(BU, 1'b0, 5'd0, 5'd0, 0);      checkOutput("wrap_up", 32'(cursorIdx), 32'd24);
    applyStimulus(BL | BR, 1'b0, 5'd0, 5'd0, 0); checkOutput("cancel_h", 32'(cursorIdx), 32'd24);
    applyStimulus(BU | BD, 1'b0, 5'd0, 5'd0, 0); checkOutput("cancel_v", 32'(cursorIdx), 32'd24);
    applyStimulus(BR | BD, 1'b0, 5'd0, 5'd0, 0); checkOutput("diag_wrap", 32'(cursorIdx), 32'd0);
    checkOutput("idle_held", 32'(held), 32'd0);

    // Swap tile 0 with tile 1; solved lags the swap by one cycle.
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 0);
    checkOutput("held_on", 32'(held), 32'd1);
    btnRight = 1'b1;
    @(negedge clk);
    btnRight = 1'b0;
    @(posedge clk);
    #1 checkOutput("swap1_count", 32'(swapCount), 32'd1);
    checkOutput("swap1_cursor", 32'(cursorIdx), 32'd1);
    checkOutput("swap1_solved_lag", 32'(solved), 32'd1);
    @(posedge clk);
    #1 checkOutput("swap1_solved", 32'(solved), 32'd0);
    @(negedge clk);
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 0);
    checkOutput("held_off", 32'(held), 32'd0);
    readTile(0, rgb); checkOutput("swapped_t0", 32'(rgb), 32'(tileColour(1)));
    readTile(1, rgb); checkOutput("swapped_t1", 32'(rgb), 32'(tileColour(0)));

    // Swap back; a center pulse landing in the SWAP cycle is dropped.
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 0);
    applyStimulus(BL, 1'b0, 5'd0, 5'd0, 0);
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 1);
    checkOutput("drop_held", 32'(held), 32'd1);
    checkOutput("swap2_cursor", 32'(cursorIdx), 32'd0);
    checkOutput("swap2_count", 32'(swapCount), 32'd2);
    checkOutput("swap2_solved", 32'(solved), 32'd1);

    // Writes are refused while held and accepted in IDLE.
    checkOutput("held_wr_ready", 32'(wrBus.wr_ready), 32'd0);
    applyStimulus(5'b0, 1'b1, 5'd3, 5'd7, 1);
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 0);
    checkOutput("idle_wr_ready", 32'(wrBus.wr_ready), 32'd1);
    readTile(3, rgb); checkOutput("wr_dropped", 32'(rgb), 32'(tileColour(3)));
    applyStimulus(5'b0, 1'b1, 5'd3, 5'd7, 1);
    readTile(3, rgb); checkOutput("wr_done", 32'(rgb), 32'(tileColour(7)));
    checkOutput("wr_unsolved", 32'(solved), 32'd0);
    applyStimulus(BR, 1'b1, 5'd3, 5'd3, 1);
    checkOutput("wr_move_cursor", 32'(cursorIdx), 32'd1);
    readTile(3, rgb); checkOutput("wr_move_tile", 32'(rgb), 32'(tileColour(3)));
    checkOutput("wr_resolved", 32'(solved), 32'd1);
    applyStimulus(BL, 1'b0, 5'd0, 5'd0, 0);
    applyStimulus(5'b0, 1'b1, 5'd25, 5'd9, 1);
    checkOutput("wr_oob_solved", 32'(solved), 32'd1);
    readTile(0, rgb); checkOutput("wr_oob_t0", 32'(rgb), 32'd0);

    // Center wins over a simultaneous direction.
    applyStimulus(BC | BR, 1'b0, 5'd0, 5'd0, 0);
    checkOutput("center_wins_held", 32'(held), 32'd1);
    checkOutput("center_wins_cursor", 32'(cursorIdx), 32'd0);
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 0);

    // Saturation of the swap counter from a preloaded value.
    force dut.swapCount_q = 16'hFFFE;
    #1 release dut.swapCount_q;
    @(negedge clk);
    checkOutput("preload", 32'(swapCount), 32'hFFFE);
    applyStimulus(BC, 1'b0, 5'd0, 5'd0, 0);
    applyStimulus(BR, 1'b0, 5'd0, 5'd0, 1);
    checkOutput("sat_reach", 32'(swapCount), 32'hFFFF);
    applyStimulus(BL, 1'b0, 5'd0, 5'd0, 1);
    checkOutput("sat_hold", 32'(swapCount), 32'hFFFF);
    checkOutput("sat_cursor", 32'(cursorIdx), 32'd0);

    // Asynchronous reset while in SWAP.
    counterX = 11'd192; counterY = 9'd112; de = 1'b1;
    btnRight = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    btnRight = 1'b0;
    #1 checkOutput("mid_rst_cursor", 32'(cursorIdx), 32'd0);
    checkOutput("mid_rst_held", 32'(held), 32'd0);
    checkOutput("mid_rst_swaps", 32'(swapCount), 32'd0);
    checkOutput("mid_rst_solved", 32'(solved), 32'd1);
    checkOutput("mid_rst_wr_ready", 32'(wrBus.wr_ready), 32'd1);
    checkOutput("mid_rst_rgb", 32'({vgaR, vgaG, vgaB}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    readTile(0, rgb); checkOutput("post_rst_t0", 32'(rgb), 32'(tileColour(0)));
    readTile(1, rgb); checkOutput("post_rst_t1", 32'(rgb), 32'(tileColour(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
